// File: rtl/serial_8051_pkg.sv
// Shared definitions for the Serial 8051 UART transmit path.
//   uart_tx_state_t : serializer FSM states
//   FRAME_BITS_*    : line frame length in bit periods (start..stop) for 8-bit data
package serial_8051_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    BIT9,
    STOP
  } uart_tx_state_t;

  localparam int unsigned FRAME_BITS_8N1 = 10;
  localparam int unsigned FRAME_BITS_9N1 = 11;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Logic-array FIFO for the UART transmit path.
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_push_req    : push strobe; accepted when not full or when popping this cycle
//   i_pop         : pop strobe from the serializer (ignored when empty)
//   i_wdata       : entry to push
//   o_rdata       : entry at the read pointer (combinational)
//   o_count       : entries held
//   o_full        : count == DEPTH
module uart_tx_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push_req,
  input  logic                     i_pop,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;
  logic          w_full;

  assign w_full = (r_count == FULL_COUNT);
  assign w_pop  = i_pop && (r_count != '0);
  // A full FIFO still accepts a push when an entry leaves on the same edge.
  assign w_push = i_push_req && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;

endmodule

// File: rtl/uart_tx_serializer.sv
// Serial 8051 UART transmitter: TX FIFO feeding an 8N1/9N1 serializer
// paced by an external baud strobe. LSB first, idle-high line.
//   clk, reset_n   : clock, asynchronous active-low reset
//   baud_tick      : one-clk strobe per bit period
//   fifo_write     : push {fifo_bit9_in, fifo_data_in}
//   nine_bit_mode  : 1 = start, data, bit9, stop (latched per frame at pop)
//   fifo_full      : FIFO holds FIFO_SIZE entries
//   fifo_count     : entries held
//   tx_out         : serial line
//   tx_busy        : serializer not idle
//   tx_done        : one-clk pulse after each completed stop bit
module uart_tx_serializer
  import serial_8051_pkg::*;
#(
  parameter int unsigned FIFO_SIZE = 4,
  parameter int unsigned WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         baud_tick,
  input  logic                         fifo_write,
  input  logic [WIDTH-1:0]             fifo_data_in,
  input  logic                         fifo_bit9_in,
  input  logic                         nine_bit_mode,
  output logic                         fifo_full,
  output logic [$clog2(FIFO_SIZE):0]   fifo_count,
  output logic                         tx_out,
  output logic                         tx_busy,
  output logic                         tx_done
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  uart_tx_state_t r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic             r_tx_out, w_tx_out_nxt;
  logic             r_bit9, w_bit9_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_tx_done, w_tx_done_nxt;
  logic             w_pop;
  logic [WIDTH:0]   w_fifo_rdata;
  logic             w_fifo_empty;

  uart_tx_fifo_mem #(
    .DEPTH (FIFO_SIZE),
    .DW    (WIDTH + 1)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push_req (fifo_write),
    .i_pop      (w_pop),
    .i_wdata    ({fifo_bit9_in, fifo_data_in}),
    .o_rdata    (w_fifo_rdata),
    .o_count    (fifo_count),
    .o_full     (fifo_full)
  );

  assign w_fifo_empty = (fifo_count == '0);

  // State register and per-frame datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx_out  <= 1'b1;
      r_bit9    <= 1'b0;
      r_mode    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx_out  <= w_tx_out_nxt;
      r_bit9    <= w_bit9_nxt;
      r_mode    <= w_mode_nxt;
      r_tx_done <= w_tx_done_nxt;
    end
  end

  // Next-state logic; everything advances only on baud_tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_out_nxt  = r_tx_out;
    w_bit9_nxt    = r_bit9;
    w_mode_nxt    = r_mode;
    w_tx_done_nxt = 1'b0;
    w_pop         = 1'b0;
    if (baud_tick) begin
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_tx_out_nxt = 1'b0;
            w_state_nxt  = START;
          end
        end
        START: begin
          w_tx_out_nxt  = r_shift[0];
          w_bit_cnt_nxt = '0;
          w_state_nxt   = DATA;
        end
        DATA: begin
          if (r_bit_cnt == BW'(WIDTH - 1)) begin
            if (r_mode) begin
              w_tx_out_nxt = r_bit9;
              w_state_nxt  = BIT9;
            end else begin
              w_tx_out_nxt = 1'b1;
              w_state_nxt  = STOP;
            end
          end else begin
            w_shift_nxt   = r_shift >> 1;
            w_tx_out_nxt  = r_shift[1];
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end
        BIT9: begin
          w_tx_out_nxt = 1'b1;
          w_state_nxt  = STOP;
        end
        STOP: begin
          w_tx_done_nxt = 1'b1;
          // Chain straight into the next start bit when data is waiting.
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_tx_out_nxt = 1'b0;
            w_state_nxt  = START;
          end else begin
            w_tx_out_nxt = 1'b1;
            w_state_nxt  = IDLE;
          end
        end
        default: begin
          w_tx_out_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end
      endcase
    end
    // Frame data, bit9 and mode are captured together at pop time.
    if (w_pop) begin
      w_shift_nxt = w_fifo_rdata[WIDTH-1:0];
      w_bit9_nxt  = w_fifo_rdata[WIDTH];
      w_mode_nxt  = nine_bit_mode;
    end
  end

  // Outputs, all decoded from registers.
  always_comb begin
    tx_out  = r_tx_out;
    tx_busy = (r_state != IDLE);
    tx_done = r_tx_done;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit path for the Serial 8051 UART: a small logic-built TX FIFO feeding an 8N1 / 9N1 serializer paced by an external bit-rate strobe. CPU-side SBUF writes push bytes and the optional ninth bit (TB8) into the FIFO. The serializer drains the FIFO back-to-back onto `tx_out` and reports each completed frame for TI generation. It is the transmit-direction counterpart of the Serial 8051 RX FIFO and shares its baud infrastructure.

## Interface
- FIFO_SIZE, 4, FIFO depth in entries; power of two, ≥2; full capacity usable
- WIDTH, 8, data bits per frame
- clk  in  1  system clock
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk
- baud_tick  in  1  one-clk strobe per bit period
- fifo_write  in  1  push strobe
- fifo_data_in  in  WIDTH  data byte to push
- fifo_bit9_in  in  1  ninth bit (TB8), stored with the byte
- nine_bit_mode  in  1  1 = 11-bit frame (start, data, bit9, stop)
- fifo_full  out  1  count == FIFO_SIZE
- fifo_count  out  $clog2(FIFO_SIZE)+1  entries held
- tx_out  out  1  serial line, idle high
- tx_busy  out  1  serializer not in IDLE
- tx_done  out  1  one-cycle pulse per completed frame

## Operation
- FIFO entries are WIDTH+1 bits: {bit9, data}. Write pointer, read pointer and count are all registered; pointers wrap modulo FIFO_SIZE.
- Push when fifo_write and (not full, or pop in the same cycle). A push while full with no pop is dropped; pointers and count are unchanged.
- Pop is internal only, issued by the serializer at frame start.
- A simultaneous push and pop leaves the count unchanged and advances both pointers.
- FSM states: IDLE, START, DATA, BIT9, STOP. State, tx_out and the shift register update only on cycles with baud_tick=1.
  - IDLE: if count≠0, pop. Load the shift register and latch bit9 and nine_bit_mode. tx_out←0. Go to START.
  - START: tx_out←data[0], bit_cnt←0. Go to DATA.
  - DATA: if bit_cnt==WIDTH-1, then if the latched mode is 1, tx_out←bit9 and go to BIT9; otherwise tx_out←1 and go to STOP. Else shift right, tx_out←next bit, bit_cnt+1.
  - BIT9: tx_out←1. Go to STOP.
  - STOP: tx_done←1 for this cycle. If count≠0, pop, tx_out←0 and go to START (back-to-back, no idle bit). Else go to IDLE with tx_out held at 1.
- LSB first.
- nine_bit_mode and bit9 are latched at pop. Changes mid-frame affect only later frames.
- tx_busy = (state≠IDLE), registered with the state.
- Reset values: tx_out=1, tx_busy=0, tx_done=0, fifo_count=0, fifo_full=0, FSM=IDLE, pointers=0. Reset mid-frame aborts it immediately: line goes high and FIFO contents are discarded.

## Timing
- Pushed data is visible in the count on the cycle after fifo_write.
- The start bit begins on the first baud_tick strictly after the push cycle. A push coincident with a tick in IDLE does not start that tick.
- tx_out changes on the clk edge of a baud_tick cycle. Each bit is exactly one tick interval.
- Frame length is 10 tick intervals (8-bit mode) or 11 (9-bit mode), start bit through stop bit.
- tx_done is high for exactly one clk: the cycle after the tick that ends the STOP bit. It is coincident with the next START edge when back-to-back.
- Pop occurs on the same edge the start bit begins. fifo_count decrements at that edge.
- Throughput at full load: one frame per 10 or 11 ticks, no gaps.

## Structure
- Shared package `serial_8051_pkg`: enum `uart_tx_state_t` {IDLE, START, DATA, BIT9, STOP} and the frame-length constants.
- Sub-module `uart_tx_fifo_mem`: logic-array storage, pointers, count and full flag, width WIDTH+1. The top level holds the FSM, shift register and bit counter.

## Test plan
- Write 0xA5 with nine_bit_mode=0 while idle; baud_tick every 16 clk → tx_out reads 0,1,0,1,0,0,1,0,1,1 over 10 bit periods; one tx_done; tx_busy returns to 0.
- nine_bit_mode=1, write 0x3C with bit9=1 → 11-bit frame 0,0,0,1,1,1,1,0,0,1,1.
- Write 4 bytes 0x01..0x04 in consecutive cycles → count=4 and full=1. A 5th write is dropped. Four contiguous frames follow with no idle bits, four tx_done pulses, then count=0.
- With the FIFO full and a pop on the STOP→START edge, write 0x77 in that same cycle → accepted, count stays 4, and 0x77 is transmitted last.
- Assert reset_n low mid-DATA, then release → tx_out=1, count=0, no tx_done, and no further frames without new writes.
- Toggle nine_bit_mode mid-frame → the current frame keeps the mode latched at its pop; the next frame uses the new mode.
